i2c_master: RTL

Single-master I2C controller that runs one complete single-byte transaction per request: START, 7-bit address plus R/W, one data byte written or read, STOP. It is the initiator counterpart to the team's I2C slave blocks (default target 0x60) and sits between a simple host-side request/response handshake and the open-drain SDA/SCL pads. It supports neither clock stretching nor multi-master arbitration.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_clk_gen.sv | 36 +++
 rtl/i2c_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C initiator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_NACK,
    STOP
  } i2c_mst_state_t;

  localparam logic       I2C_RW_WRITE      = 1'b0;
  localparam logic       I2C_RW_READ       = 1'b1;
  localparam int         I2C_BITS_PER_BYTE = 8;
  localparam logic [6:0] I2C_DEFAULT_ADDR  = 7'h60;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-bit timebase: one tick every CLK_DIV clocks, with a 2-bit quarter phase.
module i2c_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [1:0]    quarter_q;

  assign tick    = enable && (cnt_q == CW'(CLK_DIV - 1));
  assign quarter = quarter_q;

  // Held at zero while disabled so every transaction starts on a fresh Q0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else if (!enable) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else if (tick) begin
      cnt_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      cnt_q     <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, {addr,rw}, one data byte, STOP.
// No clock stretching or arbitration; SDA is open-drain (drive 0 or release).
module i2c_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter logic [6:0] DEFAULT_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl,
  inout  wire        sda
);

  i2c_mst_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_q, rx_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic       rw_q, rw_d, ack_error_q, ack_error_d, busy_q, busy_d, done_q, done_d;
  logic       scl_q, scl_d, sda_low_q, sda_low_d;
  logic       sda_meta_q, sda_sync_q;
  logic       tick, sample, bit_end, last_bit, scl_mid;
  logic [1:0] quarter;

  i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy_q),
    .tick    (tick),
    .quarter (quarter)
  );

  assign sample   = tick && (quarter == 2'd2);
  assign bit_end  = tick && (quarter == 2'd3);
  assign last_bit = (bit_cnt_q == 3'(I2C_BITS_PER_BYTE - 1));
  assign scl_mid  = (quarter == 2'd1) || (quarter == 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    ack_error_d = ack_error_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    scl_d       = 1'b1;
    sda_low_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = START;
          rw_d        = rw;
          wdata_d     = wdata;
          shift_d     = {addr, rw};
          bit_cnt_d   = 3'd0;
          ack_error_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      START: begin
        scl_d     = (quarter != 2'd3);
        sda_low_d = (quarter != 2'd0);
        if (bit_end) state_d = ADDR;
      end
      ADDR, WRITE: begin
        scl_d     = scl_mid;
        sda_low_d = !shift_q[7];
        if (bit_end) begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
        end
      end
      ADDR_ACK: begin
        scl_d = scl_mid;
        if (sample && sda_sync_q) ack_error_d = 1'b1;
        if (bit_end) begin
          if (ack_error_q) begin
            state_d = STOP;
          end else if (rw_q == I2C_RW_WRITE) begin
            state_d = WRITE;
            shift_d = wdata_q;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE_ACK: begin
        scl_d = scl_mid;
        if (sample && sda_sync_q) ack_error_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      READ: begin
        scl_d = scl_mid;
        if (sample) rx_d = {rx_q[6:0], sda_sync_q};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) state_d = READ_NACK;
        end
      end
      READ_NACK: begin
        scl_d = scl_mid;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        scl_d     = (quarter != 2'd0);
        sda_low_d = (quarter < 2'd2);
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // An address NACK on a read never clocked in a byte, so keep the old value.
          if (rw_q == I2C_RW_READ && !ack_error_q) rdata_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      rdata_q     <= 8'h00;
      wdata_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_error_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      ack_error_q <= ack_error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scl_q       <= scl_d;
      sda_low_q   <= sda_low_d;
      sda_meta_q  <= sda;
      sda_sync_q  <= sda_meta_q;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign scl       = scl_q;
  assign sda       = sda_low_q ? 1'b0 : 1'bz;

endmodule
